// File: rtl/membus_arbiter_if.sv
// Membus request/response channel: one request handshake plus an rvalid/rdata response.
// The master drives requests; the slave answers with ready, then later one rvalid pulse.
interface Membus #(
  parameter int XLEN   = 32,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic                  ready;
  logic [XLEN-1:0]       addr;
  logic                  wen;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/membus_arbiter.sv
// Fetch/data to single Membus arbiter, one outstanding transaction; MEMBUS_ARB_RR_EN selects round-robin contention.
// Latency: zero added cycles, requests and responses forwarded combinationally.
// Backpressure: downstream ready passes to the granted master only; the grant is locked while an offer stalls.
module membus_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  Membus.slave   i_membus,
  Membus.slave   d_membus,
  Membus.master  bus_membus
);

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_IFETCH = 2'd1;
  localparam logic [1:0] SRC_DATA   = 2'd2;

  logic [1:0] owner;
  logic [1:0] lock;
  logic [1:0] grant;
  logic       can_issue;
  logic       accept;

`ifdef MEMBUS_ARB_RR_EN
  // Set when fetch won last, so the first contention after reset goes to fetch.
  logic       rr_last;
`endif

  always_comb begin
    grant     = SRC_NONE;
    can_issue = (owner == SRC_NONE) || bus_membus.rvalid;
    if (!rst && can_issue) begin
      if (lock != SRC_NONE) begin
        grant = lock;
      end else if (i_membus.valid && d_membus.valid) begin
`ifdef MEMBUS_ARB_RR_EN
        grant = rr_last ? SRC_DATA : SRC_IFETCH;
`else
        grant = DATA_FIRST ? SRC_DATA : SRC_IFETCH;
`endif
      end else if (i_membus.valid) begin
        grant = SRC_IFETCH;
      end else if (d_membus.valid) begin
        grant = SRC_DATA;
      end
    end
  end

  always_comb begin
    bus_membus.valid = 1'b0;
    bus_membus.addr  = '0;
    bus_membus.wen   = 1'b0;
    bus_membus.wdata = '0;
    bus_membus.wmask = '0;
    if (grant == SRC_IFETCH) begin
      bus_membus.valid = i_membus.valid;
      bus_membus.addr  = i_membus.addr;
      bus_membus.wen   = i_membus.wen;
      bus_membus.wdata = i_membus.wdata;
      bus_membus.wmask = i_membus.wmask;
    end else if (grant == SRC_DATA) begin
      bus_membus.valid = d_membus.valid;
      bus_membus.addr  = d_membus.addr;
      bus_membus.wen   = d_membus.wen;
      bus_membus.wdata = d_membus.wdata;
      bus_membus.wmask = d_membus.wmask;
    end
  end

  assign accept = bus_membus.valid && bus_membus.ready;

  assign i_membus.ready = (grant == SRC_IFETCH) && bus_membus.ready;
  assign d_membus.ready = (grant == SRC_DATA) && bus_membus.ready;

  // Responses go only to the recorded owner; a stray rvalid with no owner is dropped.
  assign i_membus.rvalid = !rst && (owner == SRC_IFETCH) && bus_membus.rvalid;
  assign d_membus.rvalid = !rst && (owner == SRC_DATA) && bus_membus.rvalid;
  assign i_membus.rdata  = i_membus.rvalid ? bus_membus.rdata : '0;
  assign d_membus.rdata  = d_membus.rvalid ? bus_membus.rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= SRC_NONE;
      lock  <= SRC_NONE;
`ifdef MEMBUS_ARB_RR_EN
      rr_last <= 1'b0;
`endif
    end else if (accept) begin
      // A response in this same cycle belongs to the old owner; the new winner takes over at the edge.
      owner <= grant;
      lock  <= SRC_NONE;
`ifdef MEMBUS_ARB_RR_EN
      rr_last <= (grant == SRC_IFETCH);
`endif
    end else begin
      if (bus_membus.valid) begin
        lock <= grant;
      end
      if (bus_membus.rvalid) begin
        owner <= SRC_NONE;
      end
    end
  end

`ifndef SYNTHESIS
  a_rvalid_has_owner: assert property (@(posedge clk) disable iff (rst)
    bus_membus.rvalid |-> (owner != SRC_NONE));
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: reset, directed vectors, hand sequences and a randomized run against a reference model.
module tb_membus_arbiter;

  localparam bit DATA_FIRST = 1'b1;
`ifdef MEMBUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  // Winner of the first contention after reset: 1 = data.
  localparam bit CONT_D = RR ? 1'b0 : DATA_FIRST;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  Membus i_bus ();
  Membus d_bus ();
  Membus m_bus ();

  membus_arbiter #(.DATA_FIRST(DATA_FIRST)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_membus   (i_bus),
    .d_membus   (d_bus),
    .bus_membus (m_bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic        dv;
    logic        iwen;
    logic [31:0] ia;
    logic [31:0] da;
    logic        ebv;
    logic [31:0] eaddr;
    logic        eir;
    logic        edr;
    logic        edst;
  } vec_t;

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string n, input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] wm);
    chk(n, {m_bus.valid, m_bus.addr, m_bus.wen, m_bus.wdata, m_bus.wmask}, {v, a, w, wd, wm});
  endtask

  task automatic chk_rdy(input string n, input logic ei, input logic ed);
    chk(n, {i_bus.ready, d_bus.ready}, {ei, ed});
  endtask

  task automatic chk_rsp(input string n, input logic ei, input logic [31:0] eid,
                         input logic ed, input logic [31:0] edd);
    chk(n, {i_bus.rvalid, i_bus.rdata, d_bus.rvalid, d_bus.rdata}, {ei, eid, ed, edd});
  endtask

  task automatic set_i(input logic v, input logic [31:0] a);
    i_bus.valid = v;
    i_bus.addr  = a;
    i_bus.wen   = 1'b0;
    i_bus.wdata = '0;
    i_bus.wmask = '0;
  endtask

  task automatic set_d(input logic v, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] wm);
    d_bus.valid = v;
    d_bus.addr  = a;
    d_bus.wen   = w;
    d_bus.wdata = wd;
    d_bus.wmask = wm;
  endtask

  task automatic set_bus(input logic rdy, input logic rv, input logic [31:0] rd);
    m_bus.ready  = rdy;
    m_bus.rvalid = rv;
    m_bus.rdata  = rd;
  endtask

  task automatic clr();
    set_i(1'b0, '0);
    set_d(1'b0, '0, 1'b0, '0, '0);
    set_bus(1'b0, 1'b0, '0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    repeat (2) nxt();
    rst = 1'b0;
  endtask

  // Reference model state for the randomized run.
  req_t rq [2];
  int   q [$];
  int   pend;
  int   last;
  int   cnt;
  bit   outst;

  initial begin
    // Reset: outputs zero even with a master requesting and downstream ready.
    rst = 1'b1;
    clr();
    nxt();
    set_i(1'b1, 32'h8000_0000);
    set_bus(1'b1, 1'b0, '0);
    #2;
    chk_bus("rst_bus", 1'b0, '0, 1'b0, '0, '0);
    chk_rdy("rst_rdy", 1'b0, 1'b0);
    chk_rsp("rst_rsp", 1'b0, '0, 1'b0, '0);
    do_reset();
    nxt();
    #2;
    chk_bus("post_rst_bus", 1'b0, '0, 1'b0, '0, '0);
    chk_rsp("post_rst_rsp", 1'b0, '0, 1'b0, '0);

    // Directed vectors from idle: one request cycle, then one response cycle.
    tbl[0] = '{1, 1, 0, 32'h0000_1000, 32'h0000_2000, 1, CONT_D ? 32'h0000_2000 : 32'h0000_1000, !CONT_D, CONT_D, CONT_D};
    tbl[1] = '{1, 0, 0, 32'h0000_1004, 32'h0000_2004, 1, 32'h0000_1004, 1, 0, 0};
    tbl[2] = '{0, 1, 0, 32'h0000_1008, 32'h0000_2008, 1, 32'h0000_2008, 0, 1, 1};
    tbl[3] = '{0, 0, 0, 32'h0000_100C, 32'h0000_200C, 0, 32'h0, 0, 0, 0};
    tbl[4] = '{1, 1, 0, 32'h0000_1010, 32'h0000_2010, 1, CONT_D ? 32'h0000_2010 : 32'h0000_1010, !CONT_D, CONT_D, CONT_D};
    tbl[5] = '{1, 0, 1, 32'h0000_1014, 32'h0000_2014, 1, 32'h0000_1014, 1, 0, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      nxt();
      set_i(tbl[k].iv, tbl[k].ia);
      i_bus.wen = tbl[k].iwen;
      set_d(tbl[k].dv, tbl[k].da, 1'b0, '0, '0);
      set_bus(1'b1, 1'b0, '0);
      #2;
      chk($sformatf("tbl%0d_bus", k), {m_bus.valid, m_bus.addr}, {tbl[k].ebv, tbl[k].eaddr});
      chk_rdy($sformatf("tbl%0d_rdy", k), tbl[k].eir, tbl[k].edr);
      nxt();
      set_i(1'b0, '0);
      set_d(1'b0, '0, 1'b0, '0, '0);
      set_bus(1'b1, tbl[k].ebv, 32'hC0DE_0000 + k);
      #2;
      chk_rsp($sformatf("tbl%0d_rsp", k),
              tbl[k].ebv && !tbl[k].edst, (tbl[k].ebv && !tbl[k].edst) ? 32'hC0DE_0000 + k : 32'h0,
              tbl[k].ebv && tbl[k].edst,  (tbl[k].ebv && tbl[k].edst)  ? 32'hC0DE_0000 + k : 32'h0);
    end

    // Single fetch, response two cycles after acceptance.
    do_reset();
    nxt();
    set_i(1'b1, 32'h8000_0000);
    set_bus(1'b1, 1'b0, '0);
    #2;
    chk_bus("sf_bus", 1'b1, 32'h8000_0000, 1'b0, '0, '0);
    chk_rdy("sf_rdy", 1'b1, 1'b0);
    nxt();
    set_i(1'b0, '0);
    #2;
    chk_rsp("sf_wait", 1'b0, '0, 1'b0, '0);
    nxt();
    set_bus(1'b1, 1'b1, 32'h13);
    #2;
    chk_rsp("sf_rsp", 1'b1, 32'h13, 1'b0, '0);
    nxt();
    set_bus(1'b0, 1'b0, '0);
    #2;
    chk_rsp("sf_once", 1'b0, '0, 1'b0, '0);

`ifndef MEMBUS_ARB_RR_EN
    // Contention with data priority; fetch is accepted in the cycle data's response returns.
    do_reset();
    nxt();
    set_i(1'b1, 32'h8000_0000);
    set_d(1'b1, 32'h8000_0100, 1'b1, 32'hAB, 4'h1);
    set_bus(1'b1, 1'b0, '0);
    #2;
    chk_bus("ct_bus", 1'b1, 32'h8000_0100, 1'b1, 32'hAB, 4'h1);
    chk_rdy("ct_rdy", 1'b0, 1'b1);
    nxt();
    set_d(1'b0, '0, 1'b0, '0, '0);
    #2;
    chk_rdy("ct_busy_rdy", 1'b0, 1'b0);
    chk("ct_busy_vld", m_bus.valid, 1'b0);
    nxt();
    set_bus(1'b1, 1'b1, 32'h0);
    #2;
    chk_rsp("ct_d_rsp", 1'b0, '0, 1'b1, 32'h0);
    chk_bus("ct_i_bus", 1'b1, 32'h8000_0000, 1'b0, '0, '0);
    chk_rdy("ct_i_rdy", 1'b1, 1'b0);
    nxt();
    set_i(1'b0, '0);
    set_bus(1'b1, 1'b1, 32'h55);
    #2;
    chk_rsp("ct_i_rsp", 1'b1, 32'h55, 1'b0, '0);
`endif

    // Backpressure: fetch offer is locked while data arrives and downstream stalls.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      nxt();
      set_i(1'b1, 32'h8000_0200);
      if (c >= 1) set_d(1'b1, 32'h8000_0300, 1'b0, '0, '0);
      set_bus(c == 3, 1'b0, '0);
      #2;
      chk($sformatf("bp%0d_addr", c), {m_bus.valid, m_bus.addr}, {1'b1, 32'h8000_0200});
      chk_rdy($sformatf("bp%0d_rdy", c), c == 3, 1'b0);
    end
    nxt();
    set_i(1'b0, '0);
    set_bus(1'b1, 1'b0, '0);
    #2;
    chk("bp_busy", m_bus.valid, 1'b0);
    nxt();
    set_bus(1'b1, 1'b1, 32'h11);
    #2;
    chk_rsp("bp_i_rsp", 1'b1, 32'h11, 1'b0, '0);
    chk_bus("bp_d_bus", 1'b1, 32'h8000_0300, 1'b0, '0, '0);
    chk_rdy("bp_d_rdy", 1'b0, 1'b1);
    nxt();
    set_d(1'b0, '0, 1'b0, '0, '0);
    set_bus(1'b1, 1'b1, 32'h22);
    #2;
    chk_rsp("bp_d_rsp", 1'b0, '0, 1'b1, 32'h22);

    // Back-to-back: data and fetch alternate, next accept lands on the response cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      nxt();
      if (k % 2 == 0) begin
        set_d(1'b1, 32'h8000_1000 + 4 * k, 1'b0, '0, '0);
        set_i(1'b0, '0);
      end else begin
        set_i(1'b1, 32'h8000_1000 + 4 * k);
        set_d(1'b0, '0, 1'b0, '0, '0);
      end
      set_bus(1'b1, k > 0, 32'h100 + k);
      #2;
      chk_rdy($sformatf("b2b%0d_rdy", k), k % 2 == 1, k % 2 == 0);
      chk($sformatf("b2b%0d_addr", k), m_bus.addr, 32'h8000_1000 + 4 * k);
      if (k > 0)
        chk_rsp($sformatf("b2b%0d_rsp", k), k % 2 == 0, (k % 2 == 0) ? 32'h100 + k : 32'h0,
                k % 2 == 1, (k % 2 == 1) ? 32'h100 + k : 32'h0);
      nxt();
      set_i(1'b0, '0);
      set_d(1'b0, '0, 1'b0, '0, '0);
      set_bus(1'b1, 1'b0, '0);
      #2;
      chk($sformatf("b2b%0d_gap", k), m_bus.valid, 1'b0);
    end
    nxt();
    set_bus(1'b1, 1'b1, 32'h104);
    #2;
    chk_rsp("b2b_last_rsp", 1'b1, 32'h104, 1'b0, '0);

    // Reset while a fetch is in flight; a response during reset is discarded.
    do_reset();
    nxt();
    set_i(1'b1, 32'h8000_0400);
    set_bus(1'b1, 1'b0, '0);
    #2;
    chk_rdy("rm_acc", 1'b1, 1'b0);
    nxt();
    rst = 1'b1;
    clr();
    #2;
    chk_bus("rm_bus", 1'b0, '0, 1'b0, '0, '0);
    nxt();
    set_bus(1'b0, 1'b1, 32'h77);
    #2;
    chk_rsp("rm_late", 1'b0, '0, 1'b0, '0);
    nxt();
    rst = 1'b0;
    clr();
    #2;
    chk_bus("rm_idle_bus", 1'b0, '0, 1'b0, '0, '0);
    chk_rsp("rm_idle_rsp", 1'b0, '0, 1'b0, '0);
    nxt();
    set_d(1'b1, 32'h8000_0500, 1'b0, '0, '0);
    set_bus(1'b1, 1'b0, '0);
    #2;
    chk_rdy("rm_new_rdy", 1'b0, 1'b1);
    nxt();
    set_d(1'b0, '0, 1'b0, '0, '0);
    set_bus(1'b1, 1'b1, 32'h88);
    #2;
    chk_rsp("rm_new_rsp", 1'b0, '0, 1'b1, 32'h88);

`ifdef MEMBUS_ARB_RR_EN
    // Continuous contention alternates fetch, data, fetch, data.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      nxt();
      set_i(1'b1, 32'h9000_0000);
      set_d(1'b1, 32'h9000_1000, 1'b0, '0, '0);
      set_bus(1'b1, k > 0, k);
      #2;
      chk_rdy($sformatf("rr%0d_rdy", k), k % 2 == 0, k % 2 == 1);
      nxt();
      set_bus(1'b1, 1'b0, '0);
      #2;
      chk($sformatf("rr%0d_gap", k), m_bus.valid, 1'b0);
    end
    nxt();
    clr();
    set_bus(1'b0, 1'b1, 32'h4);
    #2;
    chk_rsp("rr_last_rsp", 1'b0, '0, 1'b1, 32'h4);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int m = 0; m < 2; m++) rq[m] = '{1'b0, '0, 1'b0, '0, '0};
    q.delete();
    pend  = -1;
    last  = 1;
    cnt   = 0;
    outst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        rv;
      logic        rdy;
      logic [31:0] rd;
      int          g;
      int          dst;
      bit          can;
      nxt();
      for (int m = 0; m < 2; m++) begin
        if (!rq[m].vld && $urandom_range(0, 1) == 1) begin
          rq[m].vld   = 1'b1;
          rq[m].addr  = $urandom;
          rq[m].wen   = (m == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          rq[m].wdata = (m == 1) ? $urandom : 32'h0;
          rq[m].wmask = (m == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        end
      end
      rv = 1'b0;
      if (outst) begin
        if (cnt == 0) rv = 1'b1;
        else cnt--;
      end
      rdy = ($urandom_range(0, 3) != 0);
      rd  = $urandom;
      set_i(rq[0].vld, rq[0].addr);
      set_d(rq[1].vld, rq[1].addr, rq[1].wen, rq[1].wdata, rq[1].wmask);
      set_bus(rdy, rv, rd);
      #2;
      can = (q.size() == 0) || rv;
      g = -1;
      if (can) begin
        if (pend >= 0) g = pend;
        else if (rq[0].vld && rq[1].vld) g = RR ? ((last == 1) ? 0 : 1) : (DATA_FIRST ? 1 : 0);
        else if (rq[0].vld) g = 0;
        else if (rq[1].vld) g = 1;
      end
      if (g >= 0)
        chk_bus($sformatf("rnd%0d_bus", cyc), 1'b1, rq[g].addr, rq[g].wen, rq[g].wdata, rq[g].wmask);
      else
        chk_bus($sformatf("rnd%0d_bus", cyc), 1'b0, '0, 1'b0, '0, '0);
      chk_rdy($sformatf("rnd%0d_rdy", cyc), g == 0 && rdy, g == 1 && rdy);
      dst = (rv && q.size() > 0) ? q[0] : -1;
      chk_rsp($sformatf("rnd%0d_rsp", cyc), dst == 0, (dst == 0) ? rd : 32'h0,
              dst == 1, (dst == 1) ? rd : 32'h0);
      if (rv) begin
        if (q.size() > 0) void'(q.pop_front());
        outst = 1'b0;
      end
      if (g >= 0 && rdy) begin
        q.push_back(g);
        rq[g].vld = 1'b0;
        pend  = -1;
        last  = g;
        outst = 1'b1;
        cnt   = $urandom_range(0, 2);
      end else if (g >= 0) begin
        pend = g;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
